// File: rtl/swdb_pkg.sv
// Shared defaults and configuration check for the switch debouncer.
package swdb_pkg;
  localparam int SWDB_WIDTH     = 10;
  localparam int SWDB_CNT_W     = 16;
  localparam int SWDB_DB_CYCLES = 50000;

  // The window must be at least 2 cycles, and DB_CYCLES-1 must fit in the counter.
  function automatic bit swdb_cfg_ok(input int cnt_w, input int db_cycles);
    return (db_cycles >= 2) && (cnt_w >= 1) && (cnt_w <= 62) &&
           (longint'(db_cycles) <= ((longint'(1) << cnt_w) - 1));
  endfunction
endpackage

// File: rtl/switch_debounce_bit.sv
// Single switch bit: 2-FF synchronizer, stability counter, debounced level and edge pulses.
module switch_debounce_bit
  import swdb_pkg::*;
#(
  parameter int CNT_W     = SWDB_CNT_W,
  parameter int DB_CYCLES = SWDB_DB_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw_i,
  output logic sw_db_o,
  output logic sw_rise_o,
  output logic sw_fall_o
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             db_q, rise_q, fall_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // Any sample matching the current level restarts the window.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    accept = 1'b0;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      accept = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= sw_raw_i;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      rise_q <= accept & s2_q;
      fall_q <= accept & ~s2_q;
      if (accept) db_q <= s2_q;
    end
  end

  assign sw_db_o   = db_q;
  assign sw_rise_o = rise_q;
  assign sw_fall_o = fall_q;
endmodule

// File: rtl/switch_debounce.sv
// Per-bit switch debouncer feeding the PIO in_port. Define SWDB_IRQ_EN to add
// sticky edge capture with a masked, registered interrupt; otherwise those outputs are tied 0.
module switch_debounce
  import swdb_pkg::*;
#(
  parameter int WIDTH     = SWDB_WIDTH,
  parameter int CNT_W     = SWDB_CNT_W,
  parameter int DB_CYCLES = SWDB_DB_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] edge_capture,
  output logic             irq
);
  if (!swdb_cfg_ok(CNT_W, DB_CYCLES)) begin : g_cfg_bad
    $error("switch_debounce: DB_CYCLES must be in 2..2**CNT_W-1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .CNT_W     (CNT_W),
      .DB_CYCLES (DB_CYCLES)
    ) u_bit (
      .clk       (clk),
      .reset_n   (reset_n),
      .sw_raw_i  (sw_raw[i]),
      .sw_db_o   (sw_db[i]),
      .sw_rise_o (sw_rise[i]),
      .sw_fall_o (sw_fall[i])
    );
  end

`ifdef SWDB_IRQ_EN
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             irq_q;

  // A new edge beats a same-cycle clear so no event is lost.
  always_comb cap_d = (cap_q & ~irq_clr) | sw_rise | sw_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cap_q <= cap_d;
      irq_q <= |(cap_q & irq_mask);
    end
  end

  assign edge_capture = cap_q;
  assign irq          = irq_q;
`else
  logic unused_irq_in;
  assign unused_irq_in = ^{irq_mask, irq_clr};
  assign edge_capture  = '0;
  assign irq           = 1'b0;
`endif
endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with an 8-cycle window; edge-capture checks follow SWDB_IRQ_EN.
module tb_switch_debounce;
  localparam int W  = 10;
  localparam int DB = 8;
`ifdef SWDB_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] sw_raw, sw_db, sw_rise, sw_fall, irq_mask, irq_clr, edge_capture;
  logic         irq;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  switch_debounce #(.WIDTH(W), .CNT_W(16), .DB_CYCLES(DB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sw_raw       (sw_raw),
    .sw_db        (sw_db),
    .sw_rise      (sw_rise),
    .sw_fall      (sw_fall),
    .irq_mask     (irq_mask),
    .irq_clr      (irq_clr),
    .edge_capture (edge_capture),
    .irq          (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] cap(input logic [31:0] v);
    return IRQ ? v : 32'h0;
  endfunction

  initial begin
    logic [W-1:0] pulses;
    int           rise3;
    reset_n  = 1'b0;
    sw_raw   = '0;
    irq_mask = 10'h3FF;
    irq_clr  = '0;
    cyc(2);
    chk("rst_db",   sw_db, 0);
    chk("rst_rise", sw_rise | sw_fall, 0);
    chk("rst_cap",  edge_capture, 0);
    chk("rst_irq",  irq, 0);
    reset_n = 1'b1;

    pulses = '0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      pulses |= sw_rise | sw_fall;
    end
    chk("idle_db",     sw_db, 0);
    chk("idle_pulses", pulses, 0);

    // Clean step on bit0: level appears 10 edges after the pin change.
    sw_raw = 10'h001;
    cyc(9);
    chk("step_db_early", sw_db, 10'h000);
    cyc(1);
    chk("step_db",   sw_db, 10'h001);
    chk("step_rise", sw_rise, 10'h001);
    chk("step_fall", sw_fall, 10'h000);
    cyc(1);
    chk("step_rise_end", sw_rise, 10'h000);
    chk("step_cap",      edge_capture, cap(10'h001));
    chk("step_irq_lag",  irq, 0);
    cyc(1);
    chk("step_irq", irq, cap(1));

    // Bounce on bit3: 5 high, 2 low, then held high.
    sw_raw[3] = 1'b1; cyc(5);
    sw_raw[3] = 1'b0; cyc(2);
    sw_raw[3] = 1'b1;
    rise3 = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (sw_rise[3]) rise3++;
      if (i == 9) chk("bnc_db_early", sw_db[3], 0);
    end
    chk("bnc_db",    sw_db, 10'h009);
    chk("bnc_rises", rise3, 1);
    cyc(1);
    chk("bnc_cap", edge_capture, cap(10'h009));

    // Clear collides with a new fall on bit0: set wins, then clear alone.
    sw_raw[0] = 1'b0;
    cyc(10);
    chk("cs_fall", sw_fall, 10'h001);
    chk("cs_db",   sw_db, 10'h008);
    irq_clr = 10'h001;
    cyc(1);
    chk("cs_set_wins", edge_capture, cap(10'h009));
    irq_clr = 10'h009;
    cyc(1);
    chk("cs_cleared", edge_capture, 0);
    chk("cs_irq_lag", irq, cap(1));
    irq_clr = '0;
    cyc(1);
    chk("cs_irq_off", irq, 0);

    // Masked edge on bit9, then unmask.
    irq_mask  = '0;
    sw_raw[9] = 1'b1;
    cyc(11);
    chk("msk_cap", edge_capture, cap(10'h200));
    cyc(1);
    chk("msk_irq_off", irq, 0);
    irq_mask = 10'h200;
    cyc(1);
    chk("msk_irq_on", irq, cap(1));
    irq_clr = 10'h200;
    cyc(1);
    irq_clr = '0;
    cyc(1);
    chk("msk_cleared", {22'd0, irq, edge_capture}, 0);

    // Reset mid-count on bit5 discards the partial window for every bit.
    sw_raw[5] = 1'b1;
    cyc(5);
    reset_n = 1'b0;
    cyc(1);
    chk("mrst_db",  sw_db, 0);
    chk("mrst_cap", {22'd0, irq, edge_capture}, 0);
    reset_n = 1'b1;
    cyc(9);
    chk("mrst_db_early", sw_db, 0);
    cyc(1);
    chk("mrst_db",   sw_db, 10'h228);
    chk("mrst_rise", sw_rise, 10'h228);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
